// File: rtl/hci_core_addressgen_2d_pkg.sv
// Shared types for the HCI 2-D address generator: FSM states and the latched job descriptor.
package hci_package;

    // Descriptor fields are sized for the widest supported configuration;
    // instances use the low ADDR_WIDTH / CNT_WIDTH bits.
    localparam int unsigned HCI_ADDR_W = 32;
    localparam int unsigned HCI_CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } hci_addressgen_state_t;

    typedef struct packed {
        logic [HCI_ADDR_W-1:0] base;
        logic [HCI_ADDR_W-1:0] word_stride;
        logic [HCI_ADDR_W-1:0] line_stride;
        logic [HCI_CNT_W-1:0]  word_length;
        logic [HCI_CNT_W-1:0]  line_length;
    } hci_addressgen_cfg_t;

endpackage

// File: rtl/hci_core_addressgen_2d.sv
// Two-level (word/line) strided byte-address generator feeding the TCDM streamers.
// One address per valid/ready handshake; one-cycle done pulse at the end of each job.
module hci_core_addressgen_2d
    import hci_package::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,  // up to HCI_ADDR_W
    parameter int unsigned CNT_WIDTH  = 16   // up to HCI_CNT_W
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    input  logic                   enable_i,
    input  logic                   start_i,
    input  logic [ADDR_WIDTH-1:0]  base_addr_i,
    input  logic [ADDR_WIDTH-1:0]  word_stride_i,
    input  logic [ADDR_WIDTH-1:0]  line_stride_i,
    input  logic [CNT_WIDTH-1:0]   word_length_i,
    input  logic [CNT_WIDTH-1:0]   line_length_i,
    output logic [ADDR_WIDTH-1:0]  addr_o,
    output logic                   addr_valid_o,
    input  logic                   addr_ready_i,
    output logic                   ready_start_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [2*CNT_WIDTH-1:0] addr_cnt_o
);

    localparam int unsigned TOT_W = 2 * CNT_WIDTH;

    hci_addressgen_state_t state_q, state_d;
    hci_addressgen_cfg_t   cfg_q, cfg_d;
    logic [CNT_WIDTH-1:0]  word_cnt_q, word_cnt_d;
    logic [CNT_WIDTH-1:0]  line_cnt_q, line_cnt_d;
    logic [ADDR_WIDTH-1:0] line_base_q, line_base_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  valid_q, valid_d;
    logic                  done_q, done_d;
    logic [TOT_W-1:0]      tot_cnt_q, tot_cnt_d;

    logic [ADDR_WIDTH-1:0] word_stride, line_stride;
    logic [CNT_WIDTH-1:0]  word_len, line_len;
    logic                  handshake, last_word, last_line;

    assign word_stride = cfg_q.word_stride[ADDR_WIDTH-1:0];
    assign line_stride = cfg_q.line_stride[ADDR_WIDTH-1:0];
    assign word_len    = cfg_q.word_length[CNT_WIDTH-1:0];
    assign line_len    = cfg_q.line_length[CNT_WIDTH-1:0];

    assign handshake = valid_q & addr_ready_i & enable_i;
    // Lengths are nonzero whenever RUN is reachable, so len-1 never underflows.
    assign last_word = (word_cnt_q == word_len - CNT_WIDTH'(1));
    assign last_line = (line_cnt_q == line_len - CNT_WIDTH'(1));

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q     <= IDLE;
            cfg_q       <= '0;
            word_cnt_q  <= '0;
            line_cnt_q  <= '0;
            line_base_q <= '0;
            addr_q      <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            tot_cnt_q   <= '0;
        end else if (enable_i) begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            word_cnt_q  <= word_cnt_d;
            line_cnt_q  <= line_cnt_d;
            line_base_q <= line_base_d;
            addr_q      <= addr_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
            tot_cnt_q   <= tot_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        word_cnt_d  = word_cnt_q;
        line_cnt_d  = line_cnt_q;
        line_base_d = line_base_q;
        addr_d      = addr_q;
        valid_d     = valid_q;
        done_d      = 1'b0;
        tot_cnt_d   = tot_cnt_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    cfg_d.base        = HCI_ADDR_W'(base_addr_i);
                    cfg_d.word_stride = HCI_ADDR_W'(word_stride_i);
                    cfg_d.line_stride = HCI_ADDR_W'(line_stride_i);
                    cfg_d.word_length = HCI_CNT_W'(word_length_i);
                    cfg_d.line_length = HCI_CNT_W'(line_length_i);
                    word_cnt_d  = '0;
                    line_cnt_d  = '0;
                    tot_cnt_d   = '0;
                    line_base_d = base_addr_i;
                    addr_d      = base_addr_i;
                    if ((word_length_i != '0) && (line_length_i != '0)) begin
                        state_d = RUN;
                        valid_d = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                if (handshake) begin
                    tot_cnt_d = tot_cnt_q + TOT_W'(1);
                    if (!last_word) begin
                        word_cnt_d = word_cnt_q + CNT_WIDTH'(1);
                        addr_d     = addr_q + word_stride;
                    end else if (!last_line) begin
                        word_cnt_d  = '0;
                        line_cnt_d  = line_cnt_q + CNT_WIDTH'(1);
                        line_base_d = line_base_q + line_stride;
                        addr_d      = line_base_q + line_stride;
                    end else begin
                        valid_d = 1'b0;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign addr_o        = addr_q;
    assign addr_valid_o  = valid_q;
    assign done_o        = done_q;
    assign addr_cnt_o    = tot_cnt_q;
    assign ready_start_o = (state_q == IDLE);
    assign busy_o        = (state_q == RUN);

endmodule
